// File: rtl/me_search_ctrl.sv
// Motion-estimation full-search controller: sweeps reference/search-window pel
// addresses for every candidate displacement and tracks the minimum distortion.
module me_search_ctrl #(
    parameter int unsigned BLK  = 4,
    parameter int unsigned DISP = 4,
    parameter int unsigned DW   = 16,
    localparam int unsigned RAW    = (BLK > 1) ? $clog2(BLK * BLK) : 1,
    localparam int unsigned SW     = BLK + DISP - 1,
    localparam int unsigned STRIDE = (SW > 1) ? (1 << $clog2(SW)) : 2,
    localparam int unsigned SAW    = $clog2(STRIDE * STRIDE),
    localparam int unsigned DXW    = (DISP > 1) ? $clog2(DISP) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [RAW-1:0]  r_addr,
    output logic [SAW-1:0]  s_addr,
    output logic            s1s2_mux,
    output logic            new_dist,
    input  logic [DW-1:0]   dist_in,
    input  logic            dist_valid,
    output logic [DW-1:0]   best_dist,
    output logic [DXW-1:0]  best_dx,
    output logic [DXW-1:0]  best_dy
);

    localparam int unsigned BW    = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int unsigned NCAND = DISP * DISP;
    localparam int unsigned CW    = $clog2(NCAND + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [DXW-1:0] dy, dx, dy_n, dx_n;
    logic [BW-1:0]  row, col, row_n, col_n;
    logic [CW-1:0]  res_cnt, res_cnt_n;
    logic           last_pel;
    logic           take;
    logic           emit;
    logic [SAW-1:0] s_row, s_col;

    logic           busy_n, done_n, s1s2_n, new_dist_n;
    logic [RAW-1:0] r_addr_n;
    logic [SAW-1:0] s_addr_n;
    logic [DW-1:0]  best_dist_n;
    logic [DXW-1:0] best_dx_n, best_dy_n;

    assign last_pel = (dy == DXW'(DISP - 1)) && (dx == DXW'(DISP - 1)) &&
                      (row == BW'(BLK - 1)) && (col == BW'(BLK - 1));

    // State register and all registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dy        <= '0;
            dx        <= '0;
            row       <= '0;
            col       <= '0;
            res_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            r_addr    <= '0;
            s_addr    <= '0;
            s1s2_mux  <= 1'b0;
            new_dist  <= 1'b0;
            best_dist <= '1;
            best_dx   <= '0;
            best_dy   <= '0;
        end else begin
            state     <= state_n;
            dy        <= dy_n;
            dx        <= dx_n;
            row       <= row_n;
            col       <= col_n;
            res_cnt   <= res_cnt_n;
            busy      <= busy_n;
            done      <= done_n;
            r_addr    <= r_addr_n;
            s_addr    <= s_addr_n;
            s1s2_mux  <= s1s2_n;
            new_dist  <= new_dist_n;
            best_dist <= best_dist_n;
            best_dx   <= best_dx_n;
            best_dy   <= best_dy_n;
        end
    end

    // Next state, issue counters, result tracking and next output values
    always_comb begin
        state_n     = state;
        dy_n        = dy;
        dx_n        = dx;
        row_n       = row;
        col_n       = col;
        res_cnt_n   = res_cnt;
        best_dist_n = best_dist;
        best_dx_n   = best_dx;
        best_dy_n   = best_dy;
        r_addr_n    = r_addr;
        s_addr_n    = s_addr;
        s1s2_n      = s1s2_mux;
        new_dist_n  = 1'b0;
        take        = 1'b0;
        emit        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = ISSUE;
                    dy_n        = '0;
                    dx_n        = '0;
                    row_n       = '0;
                    col_n       = '0;
                    res_cnt_n   = '0;
                    best_dist_n = '1;
                    best_dx_n   = '0;
                    best_dy_n   = '0;
                    emit        = 1'b1;
                end
            end
            ISSUE: begin
                take = dist_valid;
                if (last_pel) begin
                    state_n = WAIT;
                end else begin
                    emit = 1'b1;
                    if (col == BW'(BLK - 1)) begin
                        col_n = '0;
                        if (row == BW'(BLK - 1)) begin
                            row_n = '0;
                            if (dx == DXW'(DISP - 1)) begin
                                dx_n = '0;
                                dy_n = dy + 1'b1;
                            end else begin
                                dx_n = dx + 1'b1;
                            end
                        end else begin
                            row_n = row + 1'b1;
                        end
                    end else begin
                        col_n = col + 1'b1;
                    end
                end
            end
            WAIT: begin
                take = dist_valid;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Results arrive in issue order, so the count identifies the candidate
        if (take && (res_cnt < CW'(NCAND))) begin
            res_cnt_n = res_cnt + 1'b1;
            if (dist_in < best_dist) begin
                best_dist_n = dist_in;
                best_dx_n   = DXW'(res_cnt % DISP);
                best_dy_n   = DXW'(res_cnt / DISP);
            end
        end

        if ((state == WAIT) && (res_cnt_n == CW'(NCAND))) begin
            state_n = DONE;
        end

        s_row = SAW'(dy_n) + SAW'(row_n);
        s_col = SAW'(dx_n) + SAW'(col_n);
        if (emit) begin
            r_addr_n   = RAW'(row_n * BLK) + RAW'(col_n);
            s_addr_n   = SAW'(s_row * STRIDE) + s_col;
            s1s2_n     = (s_col < SAW'(BLK));
            new_dist_n = (row_n == '0) && (col_n == '0);
        end

        busy_n = (state_n == ISSUE) || (state_n == WAIT);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed/randomized bench for me_search_ctrl against a flat-index address
// model and an arithmetic best-match model.
module tb_me_search_ctrl;

    localparam int BLK  = 4;
    localparam int DISP = 4;
    localparam int NC   = DISP * DISP;
    localparam int NP   = NC * BLK * BLK;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        dist_valid = 1'b0;
    logic [15:0] dist_in = '0;
    logic        busy, done, s1s2_mux, new_dist;
    logic [3:0]  r_addr;
    logic [5:0]  s_addr;
    logic [15:0] best_dist;
    logic [1:0]  best_dx, best_dy;

    int n_err = 0;
    int n_chk = 0;
    int dv[NC];
    int vt[NC];

    me_search_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .r_addr     (r_addr),
        .s_addr     (s_addr),
        .s1s2_mux   (s1s2_mux),
        .new_dist   (new_dist),
        .dist_in    (dist_in),
        .dist_valid (dist_valid),
        .best_dist  (best_dist),
        .best_dx    (best_dx),
        .best_dy    (best_dy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Minimum over candidates; strict less-than keeps the earliest on ties
    task automatic model_best(output int bd, output int bx, output int by);
        bd = 65535;
        bx = 0;
        by = 0;
        for (int i = 0; i < NC; i++) begin
            if (dv[i] < bd) begin
                bd = dv[i];
                bx = i % DISP;
                by = i / DISP;
            end
        end
    endtask

    task automatic sched_random(input int max_lat);
        for (int i = 0; i < NC; i++) begin
            dv[i] = int'($urandom_range(0, 63));
            vt[i] = 16 * i + 15 + int'($urandom_range(0, max_lat));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_new_dist"}, 32'(new_dist), 0);
        chk({tag, "_s1s2"}, 32'(s1s2_mux), 0);
        chk({tag, "_r_addr"}, 32'(r_addr), 0);
        chk({tag, "_s_addr"}, 32'(s_addr), 0);
        chk({tag, "_best_dist"}, 32'(best_dist), 32'hFFFF);
        chk({tag, "_best_dx"}, 32'(best_dx), 0);
        chk({tag, "_best_dy"}, 32'(best_dy), 0);
    endtask

    // Call at a falling edge; runs one search using dv/vt and checks every cycle
    task automatic run_search(input string tag, input bit poke);
        int k, nd_cnt, exp_done_t, bd, bx, by;
        int cand, pel, dy, dx, row, col;
        k = 0;
        nd_cnt = 0;
        exp_done_t = (vt[NC-1] >= NP) ? vt[NC-1] + 1 : NP + 1;
        start = 1'b1;
        for (int t = 0; t <= exp_done_t + 2; t++) begin
            @(negedge clock);
            start = 1'b0;
            dist_valid = 1'b0;
            if (t < NP) begin
                cand = t / 16;
                pel  = t % 16;
                dy = cand / DISP;
                dx = cand % DISP;
                row = pel / BLK;
                col = pel % BLK;
                chk({tag, "_r_addr"}, 32'(r_addr), row * BLK + col);
                chk({tag, "_s_addr"}, 32'(s_addr), (dy + row) * 8 + dx + col);
                chk({tag, "_s1s2"}, 32'(s1s2_mux), ((dx + col) < BLK) ? 1 : 0);
                chk({tag, "_new_dist"}, 32'(new_dist), (pel == 0) ? 1 : 0);
                if (new_dist === 1'b1) nd_cnt++;
            end else begin
                chk({tag, "_hold_r_addr"}, 32'(r_addr), 15);
                chk({tag, "_hold_s_addr"}, 32'(s_addr), 54);
                chk({tag, "_idle_new_dist"}, 32'(new_dist), 0);
            end
            chk({tag, "_busy"}, 32'(busy), (t < exp_done_t) ? 1 : 0);
            chk({tag, "_done"}, 32'(done), (t == exp_done_t) ? 1 : 0);
            if (k < NC && vt[k] == t) begin
                dist_valid = 1'b1;
                dist_in = 16'(dv[k]);
                k++;
            end
            if ((poke && (t == 50 || t == NP + 3)) || t == exp_done_t) start = 1'b1;
        end
        chk({tag, "_new_dist_count"}, nd_cnt, NC);
        model_best(bd, bx, by);
        chk({tag, "_best_dist"}, 32'(best_dist), bd);
        chk({tag, "_best_dx"}, 32'(best_dx), bx);
        chk({tag, "_best_dy"}, 32'(best_dy), by);
        // A stray result while idle must not disturb the held result
        dist_valid = 1'b1;
        dist_in = 16'd0;
        @(negedge clock);
        dist_valid = 1'b0;
        @(negedge clock);
        chk({tag, "_idle_best_dist"}, 32'(best_dist), bd);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int bd, bx, by;
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // One clear winner at candidate 9
        for (int i = 0; i < NC; i++) begin
            dv[i] = (i == 9) ? 20 : 100;
            vt[i] = 16 * i + 17;
        end
        run_search("single_min", 1'b0);

        // Equal minima at 3 and 12, with start pokes while busy
        sched_random(6);
        for (int i = 0; i < NC; i++) dv[i] = (i == 3 || i == 12) ? 7 : 50;
        run_search("tie", 1'b1);

        // Final result held back 40 cycles past the sweep
        sched_random(1);
        vt[NC-1] = NP - 1 + 40;
        run_search("late_last", 1'b1);

        // Final result lands on the ISSUE-to-WAIT edge
        for (int i = 0; i < NC; i++) begin
            dv[i] = int'($urandom_range(0, 63));
            vt[i] = 16 * i + 15;
        end
        run_search("edge_last", 1'b0);

        for (int r = 0; r < 3; r++) begin
            sched_random(10);
            run_search("random", 1'b0);
        end

        // Abort mid-sweep with results already folded in
        sched_random(1);
        for (int i = 0; i < NC; i++) dv[i] = int'($urandom_range(0, 30));
        start = 1'b1;
        for (int t = 0; t <= 100; t++) begin
            @(negedge clock);
            start = 1'b0;
            dist_valid = 1'b0;
            if (t == 100) begin
                reset_n = 1'b0;
                #1;
                check_reset_values("abort");
            end else begin
                for (int i = 0; i < NC; i++) begin
                    if (vt[i] == t) begin
                        dist_valid = 1'b1;
                        dist_in = 16'(dv[i]);
                    end
                end
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("post_abort_busy", 32'(busy), 0);
            chk("post_abort_r_addr", 32'(r_addr), 0);
            chk("post_abort_new_dist", 32'(new_dist), 0);
        end
        sched_random(4);
        run_search("after_abort", 1'b0);
        model_best(bd, bx, by);
        chk("final_best_dist", 32'(best_dist), bd);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
